// File: rtl/serial_acc_ctrl.sv
// serial_acc_ctrl
// ---------------
// Accumulates N_TERMS signed operands into an ACC_W-bit accumulator.
// A single 1-bit full-adder slice is reused for every bit, so each
// operand takes ACC_W cycles to add. Bits are processed LSB first.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any run in progress
//   start      begins a run; only sampled in IDLE
//   in_data    signed operand (DATA_W bits)
//   in_valid   operand available
//   in_ready   block accepts an operand (high only in WAIT_IN)
//   out_acc    accumulated result; stays stable while out_valid is high
//   out_valid  result available
//   out_ready  consumer accepts the result
//   busy       high in any state other than IDLE
//   overflow   sticky signed overflow flag for the current run
//
// Handshake semantics: a transfer happens on a rising clock edge where
// valid and ready are both high. The sender holds data stable until it
// transfers. The receiver may hold ready low for any number of cycles.
module serial_acc_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overflow
);

  localparam int BIT_W  = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam int TERM_W = $clog2(N_TERMS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    ADD     = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  op;
  logic              carry;
  logic [BIT_W-1:0]  bit_cnt;
  logic [TERM_W-1:0] term_cnt;

  // Full-adder slice working on the current LSBs
  logic             sum_bit;
  logic             carry_nxt;
  logic [ACC_W-1:0] acc_nxt;
  logic             last_bit;
  logic             last_term;

  always_comb begin
    sum_bit   = acc[0] ^ op[0] ^ carry;
    carry_nxt = (acc[0] & op[0]) | (acc[0] & carry) | (op[0] & carry);
    // Rotating the sum into the MSB leaves the result aligned after ACC_W steps
    acc_nxt   = {sum_bit, acc[ACC_W-1:1]};
    last_bit  = (bit_cnt == BIT_W'(ACC_W - 1));
    last_term = (term_cnt == TERM_W'(N_TERMS - 1));
  end

  assign in_ready = (state == WAIT_IN);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      op        <= '0;
      carry     <= 1'b0;
      bit_cnt   <= '0;
      term_cnt  <= '0;
      overflow  <= 1'b0;
      out_acc   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            term_cnt <= '0;
            overflow <= 1'b0;
            out_acc  <= '0;
            state    <= WAIT_IN;
          end
        end

        WAIT_IN: begin
          if (in_valid) begin
            op      <= ACC_W'($signed(in_data));
            carry   <= 1'b0;
            bit_cnt <= '0;
            state   <= ADD;
          end
        end

        ADD: begin
          acc     <= acc_nxt;
          op      <= op >> 1;
          carry   <= carry_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            // Signed overflow: carry into the sign bit differs from carry out
            overflow <= overflow | (carry ^ carry_nxt);
            term_cnt <= term_cnt + 1'b1;
            if (last_term) begin
              out_acc   <= acc_nxt;
              out_valid <= 1'b1;
              state     <= OUTPUT;
            end else begin
              state <= WAIT_IN;
            end
          end
        end

        OUTPUT: begin
          // start is deliberately ignored here; a new run needs start in IDLE
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_acc_ctrl.sv
module tb_serial_acc_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       sel;   // 0: default instance (ACC_W=16, N=4), 1: ACC_W=8, N=2

  // default instance
  logic        start16;
  logic        in_ready16, out_valid16, busy16, overflow16;
  logic [15:0] out_acc16;
  // small instance
  logic        start8;
  logic        in_ready8, out_valid8, busy8, overflow8;
  logic [7:0]  out_acc8;

  assign start16 = start & ~sel;
  assign start8  = start & sel;

  serial_acc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start16), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready16), .out_acc(out_acc16),
    .out_valid(out_valid16), .out_ready(out_ready), .busy(busy16),
    .overflow(overflow16)
  );

  serial_acc_ctrl #(.DATA_W(8), .ACC_W(8), .N_TERMS(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready8), .out_acc(out_acc8),
    .out_valid(out_valid8), .out_ready(out_ready), .busy(busy8),
    .overflow(overflow8)
  );

  logic        in_ready, out_valid, busy, overflow;
  logic [15:0] out_acc;
  assign in_ready  = sel ? in_ready8  : in_ready16;
  assign out_valid = sel ? out_valid8 : out_valid16;
  assign busy      = sel ? busy8      : busy16;
  assign overflow  = sel ? overflow8  : overflow16;
  assign out_acc   = sel ? {8'h00, out_acc8} : out_acc16;

  // ---------------- bookkeeping ----------------
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // busy must stay high for the whole run
  logic mon_busy = 1'b0;
  int   busy_err = 0;
  int   busy_base = 0;
  always @(negedge clk) if (mon_busy && busy !== 1'b1) busy_err <= busy_err + 1;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic        ovf_q[$];
  logic [15:0] model_acc;
  logic        model_ovf;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_add(input logic [7:0] d);
    logic [15:0] b, s;
    logic        ov;
    if (sel) begin
      s  = {8'h00, model_acc[7:0] + d};
      ov = (model_acc[7] == d[7]) && (s[7] != d[7]);
    end else begin
      b  = {{8{d[7]}}, d};
      s  = model_acc + b;
      ov = (model_acc[15] == b[15]) && (s[15] != b[15]);
    end
    model_ovf = model_ovf | ov;
    model_acc = s;
  endtask

  task automatic end_run();
    exp_q.push_back(model_acc);
    ovf_q.push_back(model_ovf);
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_start();
    model_acc = 16'h0;
    model_ovf = 1'b0;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    busy_base = busy_err;
    mon_busy = 1'b1;
  endtask

  // gap: cycles to stall in WAIT_IN; pulse: pulse start during the ADD phase
  task automatic send(input logic [7:0] d, input int gap, input bit pulse);
    int n;
    logic [1:0] st0;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {15'h0, in_ready}, 16'h1);
    st0 = dut.state;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check("stall_in_ready", {15'h0, in_ready}, 16'h1);
      check("stall_state", {14'h0, dut.state}, {14'h0, st0});
    end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
    model_add(d);
    if (pulse) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // stall: cycles out_ready stays low; pulse: pulse start in OUTPUT and
  // again together with out_ready; lat: expected rise latency (-1 = skip)
  task automatic wait_out(input int stall, input bit pulse, input int lat);
    int n;
    logic [15:0] expv, held;
    logic        expo;
    n = 0;
    while (out_valid !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_rise", {15'h0, out_valid}, 16'h1);
    if (lat >= 0) check("latency", 16'(cyc - t0), 16'(lat));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 16'h1, 16'h0);
      expv = 16'h0;
      expo = 1'b0;
    end else begin
      expv = exp_q.pop_front();
      expo = ovf_q.pop_front();
    end
    check("out_acc", out_acc, expv);
    check("overflow", {15'h0, overflow}, {15'h0, expo});
    held = out_acc;
    for (int i = 0; i < stall; i++) begin
      if (pulse && i == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("hold_valid", {15'h0, out_valid}, 16'h1);
      check("hold_acc", out_acc, held);
    end
    mon_busy = 1'b0;
    check("busy_throughout", 16'(busy_err - busy_base), 16'h0);
    out_ready = 1'b1;
    start = pulse;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("idle_busy", {15'h0, busy}, 16'h0);
    check("idle_valid", {15'h0, out_valid}, 16'h0);
    check("idle_acc_kept", out_acc, held);
    @(negedge clk);
    check("idle_stays", {15'h0, busy}, 16'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc"},      out_acc, 16'h0);
    check({tag, "_valid"},    {15'h0, out_valid}, 16'h0);
    check({tag, "_busy"},     {15'h0, busy}, 16'h0);
    check({tag, "_in_ready"}, {15'h0, in_ready}, 16'h0);
    check({tag, "_overflow"}, {15'h0, overflow}, 16'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 8'h00; sel = 1'b0;
    model_acc = 16'h0; model_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1,2,3,4 back to back: latency and result
    do_start();
    send(8'd1, 0, 1'b0);
    send(8'd2, 0, 1'b0);
    send(8'd3, 0, 1'b0);
    send(8'd4, 0, 1'b0);
    end_run();
    wait_out(0, 1'b0, 69);

    // -1 x4 with input stall before term 3 and output backpressure
    do_start();
    send(8'hFF, 0, 1'b0);
    send(8'hFF, 0, 1'b0);
    send(8'hFF, 5, 1'b0);
    send(8'hFF, 0, 1'b0);
    end_run();
    wait_out(10, 1'b0, -1);

    // 8-bit accumulator, 2 terms: overflow, then cleared by next start
    sel = 1'b1;
    @(negedge clk);
    do_start();
    send(8'd100, 0, 1'b0);
    send(8'd100, 0, 1'b0);
    end_run();
    wait_out(0, 1'b0, -1);
    do_start();
    send(8'd0, 0, 1'b0);
    send(8'd0, 0, 1'b0);
    end_run();
    wait_out(0, 1'b0, -1);
    sel = 1'b0;
    @(negedge clk);

    // start pulses during ADD and OUTPUT are ignored
    do_start();
    send(8'd5, 0, 1'b0);
    send(8'd5, 0, 1'b1);
    send(8'd5, 0, 1'b0);
    send(8'd5, 0, 1'b0);
    end_run();
    wait_out(3, 1'b1, -1);

    // reset in the middle of ADD for term 2 aborts the run
    do_start();
    send(8'd9, 0, 1'b0);
    send(8'd3, 0, 1'b0);
    mon_busy = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_output", {15'h0, out_valid}, 16'h0);

    do_start();
    send(8'd7, 0, 1'b0);
    send(8'd0, 0, 1'b0);
    send(8'd0, 0, 1'b0);
    send(8'd1, 0, 1'b0);
    end_run();
    wait_out(0, 1'b0, -1);

    check("scoreboard_drained", 16'(exp_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
